// File: rtl/config_stream_pkg.sv
// Purpose: shared types and codes for the CDC config stream loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package config_stream_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      LEN,
      PAYLOAD,
      CHECK,
      RESP
   } state_t;

   localparam logic [7:0] CMD_PING    = 8'h00;
   localparam logic [7:0] CMD_WRITE   = 8'h01;

   localparam logic [7:0] ST_ACK      = 8'h00;
   localparam logic [7:0] ST_BAD_CSUM = 8'hE1;
   localparam logic [7:0] ST_BAD_CMD  = 8'hE2;
   localparam logic [7:0] ST_BAD_LEN  = 8'hE3;

endpackage

// File: rtl/config_stream_loader_word_assembler.sv
// Purpose: packs payload bytes into WORD_BYTES-wide config words.
// Latency: last byte of a word accepted -> write_strobe high the next cycle.
// Backpressure: none internally; the parent stalls byte_en during the strobe cycle.
// Ports: byte_data/byte_en = accepted payload byte; word_done = this byte completes a word;
//        write_data/write_strobe = completed word, held until the next strobe.
module word_assembler #(
   parameter int WORD_BYTES = 4,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic [7:0]              byte_data,
   input  logic                    byte_en,
   output logic                    word_done,
   output logic [8*WORD_BYTES-1:0] write_data,
   output logic                    write_strobe
);

   localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WORD_BYTES - 1);

   logic [IW-1:0]           idx;
   logic [8*WORD_BYTES-1:0] asm_q;
   logic [8*WORD_BYTES-1:0] asm_nxt;

   // Bytes are dropped into their final lane rather than shifted, so the
   // completed word can be captured in the same cycle as its last byte.
   always_comb begin
      asm_nxt = asm_q;
      if (MSB_FIRST) begin
         asm_nxt[8*(WORD_BYTES-1-int'(idx)) +: 8] = byte_data;
      end else begin
         asm_nxt[8*int'(idx) +: 8] = byte_data;
      end
   end

   assign word_done = byte_en && (idx == LAST_IDX);

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         idx          <= '0;
         asm_q        <= '0;
         write_data   <= '0;
         write_strobe <= 1'b0;
      end else begin
         write_strobe <= word_done;
         if (byte_en) begin
            asm_q <= asm_nxt;
            idx   <= word_done ? '0 : idx + 1'b1;
         end
         if (word_done) begin
            write_data <= asm_nxt;
         end
      end
   end

endmodule

// File: rtl/config_stream_loader.sv
// Purpose: parses framed CDC byte packets (sync, cmd, len, payload, xor checksum) into config words.
// Latency: byte -> word strobe 1 cycle; checksum byte -> status valid 1 cycle.
// Backpressure: out_ready_o drops in RESP and in strobe cycles; status held until in_ready_i.
// Ports: out_* = CDC OUT byte stream, in_* = CDC IN status byte, write_data_o/word_write_strobe_o =
//        config word write, busy_o = frame in progress, error_count_o = saturating non-ACK count.
module config_stream_loader
   import config_stream_pkg::*;
#(
   parameter int          WORD_BYTES = 4,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
   parameter int          LEN_WIDTH  = 16
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic [7:0]              out_data_i,
   input  logic                    out_valid_i,
   output logic                    out_ready_o,
   output logic [7:0]              in_data_o,
   output logic                    in_valid_o,
   input  logic                    in_ready_i,
   output logic [8*WORD_BYTES-1:0] write_data_o,
   output logic                    word_write_strobe_o,
   output logic                    busy_o,
   output logic [7:0]              error_count_o
);

   localparam int LEN_BYTES = LEN_WIDTH / 8;
   localparam int LIW       = (LEN_BYTES > 1) ? $clog2(LEN_BYTES) : 1;
   localparam logic [LIW-1:0] LEN_LAST = LIW'(LEN_BYTES - 1);

   state_t               state, state_nxt;
   logic                 accept;
   logic                 word_done;
   logic [LEN_WIDTH-1:0] word_cnt;
   logic [LEN_WIDTH-1:0] len_nxt;
   logic [LIW-1:0]       len_idx;
   logic                 is_ping;
   logic [7:0]           csum;
   logic [7:0]           status, status_nxt;
   logic [7:0]           err_cnt;

   // Reset gating keeps every output low while reset is held.
   assign out_ready_o   = reset_n_i && (state != RESP) && !word_write_strobe_o;
   assign accept        = out_valid_i && out_ready_o;
   assign len_nxt       = (word_cnt << 8) | LEN_WIDTH'(out_data_i);
   assign busy_o        = (state != IDLE);
   assign error_count_o = err_cnt;

   word_assembler #(
      .WORD_BYTES (WORD_BYTES),
      .MSB_FIRST  (MSB_FIRST)
   ) u_asm (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .byte_data    (out_data_i),
      .byte_en      (accept && (state == PAYLOAD)),
      .word_done    (word_done),
      .write_data   (write_data_o),
      .write_strobe (word_write_strobe_o)
   );

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      status_nxt = status;
      in_valid_o = 1'b0;
      in_data_o  = 8'h00;
      case (state)
         IDLE: begin
            if (accept && out_data_i == SYNC_BYTE) state_nxt = CMD;
         end
         CMD: begin
            if (accept) begin
               if (out_data_i == CMD_WRITE || out_data_i == CMD_PING) begin
                  state_nxt = LEN;
               end else begin
                  status_nxt = ST_BAD_CMD;
                  state_nxt  = RESP;
               end
            end
         end
         LEN: begin
            if (accept && len_idx == LEN_LAST) begin
               if (is_ping && len_nxt != '0) begin
                  status_nxt = ST_BAD_LEN;
                  state_nxt  = RESP;
               end else if (len_nxt == '0) begin
                  state_nxt = CHECK;
               end else begin
                  state_nxt = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            // word_cnt is at least 1 here; the word finishing now is the last one.
            if (word_done && word_cnt == LEN_WIDTH'(1)) state_nxt = CHECK;
         end
         CHECK: begin
            if (accept) begin
               status_nxt = (out_data_i == csum) ? ST_ACK : ST_BAD_CSUM;
               state_nxt  = RESP;
            end
         end
         RESP: begin
            in_valid_o = 1'b1;
            in_data_o  = status;
            if (in_ready_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         word_cnt <= '0;
         len_idx  <= '0;
         is_ping  <= 1'b0;
         csum     <= 8'h00;
         status   <= 8'h00;
         err_cnt  <= 8'h00;
      end else begin
         status <= status_nxt;
         case (state)
            IDLE: begin
               if (accept && out_data_i == SYNC_BYTE) csum <= 8'h00;
            end
            CMD: begin
               if (accept) begin
                  is_ping <= (out_data_i == CMD_PING);
                  len_idx <= '0;
               end
            end
            LEN: begin
               if (accept) begin
                  word_cnt <= len_nxt;
                  len_idx  <= len_idx + 1'b1;
               end
            end
            PAYLOAD: begin
               if (accept)    csum     <= csum ^ out_data_i;
               if (word_done) word_cnt <= word_cnt - 1'b1;
            end
            RESP: begin
               if (in_ready_i && status != ST_ACK && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
